serial_cmd_parser: RTL and testbench

SERIAL_CMD_PARSER -- requirements
Module: serial_cmd_parser

---
 rtl/serial_cmd_pkg.sv | 26 ++
 rtl/serial_cmd_buf.sv | 25 ++
 rtl/serial_cmd_parser.sv | 212 +++++++++++++++++++++
 tb/tb_serial_cmd_parser.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_cmd_pkg.sv
// serial_cmd_pkg: shared types and constants for the serial command parser.
//   - state_e       : parser FSM states
//   - ERR_*         : err_code encodings reported with pkt_err
//   - DEFAULT_SYNC_BYTE : default packet start marker
// Optional feature macro: SERIAL_CMD_CHECKSUM_EN (adds the CHECK state).
package serial_cmd_pkg;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    localparam logic [1:0] ERR_LEN     = 2'd0;
    localparam logic [1:0] ERR_CHK     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
`ifdef SERIAL_CMD_CHECKSUM_EN
        ST_CHECK   = 3'd4,
`endif
        ST_COMMIT  = 3'd5
    } state_e;

endpackage

// File: rtl/serial_cmd_buf.sv
// serial_cmd_buf: DEPTH x 8 payload register file.
//   clk           : write clock
//   we/waddr/wdata: synchronous write port
//   raddr/rdata   : combinational read port (out-of-range reads return 0)
// Contents are not reset; the parser never reads an entry it has not written.
module serial_cmd_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = (int'(raddr) < DEPTH) ? mem_q[raddr] : 8'h00;

endmodule

// File: rtl/serial_cmd_parser.sv
// serial_cmd_parser: byte-stream packet parser issuing register writes.
//   Packet: SYNC, ADDR, LEN, LEN payload bytes [, CHK].
//   clk, rst_n            : clock, async active-low reset
//   rx_data, rx_new_data  : incoming byte + single-cycle accept strobe
//   wr_en/wr_addr/wr_data : one write per payload byte, ADDR+i (8-bit wrap)
//   pkt_ok, pkt_err       : 1-cycle completion / abort pulses
//   err_code              : cause of last abort, held until the next one
//   busy                  : FSM not in IDLE
// Macro SERIAL_CMD_CHECKSUM_EN: when defined, a CHK byte (8-bit sum of ADDR,
// LEN and payload) follows the payload and must match before committing.
module serial_cmd_parser
    import serial_cmd_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_new_data,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       pkt_ok,
    output logic       pkt_err,
    output logic [1:0] err_code,
    output logic       busy
);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int GW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CLKS - 1);

    state_e        state_q, state_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    idx_q, idx_d;     // payload index while receiving, write index in COMMIT
    logic [GW-1:0] gap_q, gap_d;
    logic          wr_en_q, wr_en_d;
    logic [7:0]    wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          pkt_ok_q, pkt_ok_d;
    logic          pkt_err_q, pkt_err_d;
    logic [1:0]    err_code_q, err_code_d;
`ifdef SERIAL_CMD_CHECKSUM_EN
    logic [7:0]    chk_q, chk_d;
`endif
    logic          in_pkt;
    logic          buf_we;
    logic [7:0]    buf_rdata;

    serial_cmd_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (idx_q[AW-1:0]),
        .wdata (rx_data),
        .raddr (idx_q[AW-1:0]),
        .rdata (buf_rdata)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        idx_d      = idx_q;
        gap_d      = '0;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        pkt_ok_d   = 1'b0;
        pkt_err_d  = 1'b0;
        err_code_d = err_code_q;
        buf_we     = 1'b0;
`ifdef SERIAL_CMD_CHECKSUM_EN
        chk_d      = chk_q;
`endif
        in_pkt = (state_q != ST_IDLE) && (state_q != ST_COMMIT);

        // Byte-gap watchdog; a byte arriving on the last allowed cycle still wins.
        if (in_pkt && !rx_new_data) begin
            if (gap_q == GAP_LAST) begin
                state_d    = ST_IDLE;
                pkt_err_d  = 1'b1;
                err_code_d = ERR_TIMEOUT;
            end else begin
                gap_d = gap_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_new_data && rx_data == SYNC_BYTE) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                if (rx_new_data) begin
                    addr_d  = rx_data;
                    state_d = ST_LEN;
`ifdef SERIAL_CMD_CHECKSUM_EN
                    chk_d   = rx_data;
`endif
                end
            end
            ST_LEN: begin
                if (rx_new_data) begin
                    len_d = rx_data;
                    idx_d = '0;
`ifdef SERIAL_CMD_CHECKSUM_EN
                    chk_d = chk_q + rx_data;
`endif
                    if (rx_data == 8'd0 || int'(rx_data) > MAX_LEN) begin
                        state_d    = ST_IDLE;
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_LEN;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rx_new_data) begin
                    buf_we = 1'b1;
                    idx_d  = idx_q + 8'd1;
`ifdef SERIAL_CMD_CHECKSUM_EN
                    chk_d  = chk_q + rx_data;
                    if (idx_q == len_q - 8'd1) state_d = ST_CHECK;
`else
                    if (idx_q == len_q - 8'd1) begin
                        state_d = ST_COMMIT;
                        idx_d   = '0;
                    end
`endif
                end
            end
`ifdef SERIAL_CMD_CHECKSUM_EN
            ST_CHECK: begin
                if (rx_new_data) begin
                    idx_d = '0;
                    if (rx_data == chk_q) begin
                        state_d = ST_COMMIT;
                    end else begin
                        state_d    = ST_IDLE;
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_CHK;
                    end
                end
            end
`endif
            ST_COMMIT: begin
                // Bytes arriving now are dropped; the commit itself carries on.
                if (rx_new_data) begin
                    pkt_err_d  = 1'b1;
                    err_code_d = ERR_OVERRUN;
                end
                // Outputs are registered, so the final COMMIT cycle (idx==len)
                // lands pkt_ok right after the last wr_en, together with IDLE.
                if (idx_q == len_q) begin
                    state_d  = ST_IDLE;
                    pkt_ok_d = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q + idx_q;
                    wr_data_d = buf_rdata;
                    idx_d     = idx_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            gap_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            pkt_ok_q   <= 1'b0;
            pkt_err_q  <= 1'b0;
            err_code_q <= '0;
`ifdef SERIAL_CMD_CHECKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            pkt_ok_q   <= pkt_ok_d;
            pkt_err_q  <= pkt_err_d;
            err_code_q <= err_code_d;
`ifdef SERIAL_CMD_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign pkt_ok   = pkt_ok_q;
    assign pkt_err  = pkt_err_q;
    assign err_code = err_code_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_cmd_parser.sv
// tb_serial_cmd_parser: directed packets; expected writes and ok/err events
// are queued at stimulus time and popped by an independent output monitor.
module tb_serial_cmd_parser;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_new_data;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       pkt_ok;
    logic       pkt_err;
    logic [1:0] err_code;
    logic       busy;

    wr_t        wq[$];
    logic [2:0] eq[$];     // 0..3 = pkt_err with that err_code, 4 = pkt_ok
    int         n_vec = 0;
    int         n_err = 0;
    logic       prev_wr = 1'b0;

    serial_cmd_parser dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_new_data (rx_new_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .pkt_ok      (pkt_ok),
        .pkt_err     (pkt_err),
        .err_code    (err_code),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Output monitor: samples on the falling edge, away from register updates.
    always @(negedge clk) begin
        wr_t        w;
        logic [2:0] e;
        if (pkt_err) begin
            if (eq.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_pkt_err: got err_code %0d, expected no event", err_code);
            end else begin
                e = eq.pop_front();
                check("pkt_err_code", {29'd0, 1'b0, err_code}, {29'd0, e});
            end
        end
        if (wr_en) begin
            if (wq.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_wr: got %0h<-%0h, expected no write", wr_addr, wr_data);
            end else begin
                w = wq.pop_front();
                check("wr_addr", {24'd0, wr_addr}, {24'd0, w.a});
                check("wr_data", {24'd0, wr_data}, {24'd0, w.d});
            end
        end
        if (pkt_ok) begin
            if (eq.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_pkt_ok: got 1, expected no event");
            end else begin
                e = eq.pop_front();
                check("pkt_ok_event", 32'd4, {29'd0, e});
                check("pkt_ok_after_wr", {31'd0, prev_wr}, 32'd1);
                check("idle_with_ok", {31'd0, busy}, 32'd0);
            end
        end
        // A write run may only end into pkt_ok (writes are contiguous).
        if (prev_wr && !wr_en) check("wr_run_end", {31'd0, pkt_ok}, 32'd1);
        prev_wr = wr_en;
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data     = b;
        rx_new_data = 1'b1;
        @(negedge clk);
        rx_new_data = 1'b0;
    endtask

    task automatic send_chk(input logic [7:0] c);
`ifdef SERIAL_CMD_CHECKSUM_EN
        send(c);
`else
        if (c == 8'hxx) send(c);   // checksum byte not part of the packet
`endif
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        wq.push_back(w);
    endtask

    task automatic wait_done(input string name, input int bound);
        int n = 0;
        while ((wq.size() != 0 || eq.size() != 0) && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (wq.size() != 0 || eq.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL %s_timeout: got %0d writes and %0d events pending, expected 0", name, wq.size(), eq.size());
            wq.delete();
            eq.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [7:0] sum;
        rst_n       = 1'b0;
        rx_data     = 8'h00;
        rx_new_data = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr_en",    {31'd0, wr_en},    32'd0);
        check("rst_wr_addr",  {24'd0, wr_addr},  32'd0);
        check("rst_wr_data",  {24'd0, wr_data},  32'd0);
        check("rst_pkt_ok",   {31'd0, pkt_ok},   32'd0);
        check("rst_pkt_err",  {31'd0, pkt_err},  32'd0);
        check("rst_err_code", {30'd0, err_code}, 32'd0);
        check("rst_busy",     {31'd0, busy},     32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Two-byte write, good checksum 0x45.
        push_wr(8'h10, 8'h11); push_wr(8'h11, 8'h22); eq.push_back(3'd4);
        send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send_chk(8'h45);
        wait_done("basic", 50);

`ifdef SERIAL_CMD_CHECKSUM_EN
        // Bad checksum: abort, no writes.
        eq.push_back(3'd1);
        send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'h46);
        wait_done("bad_chk", 50);
        check("bad_chk_code_held", {30'd0, err_code}, 32'd1);
`endif

        // Address wrap FF -> 00 (sum FF+02+AA+BB = 0x66).
        push_wr(8'hFF, 8'hAA); push_wr(8'h00, 8'hBB); eq.push_back(3'd4);
        send(8'hA5); send(8'hFF); send(8'h02); send(8'hAA); send(8'hBB); send_chk(8'h66);
        wait_done("addr_wrap", 50);

        // Bytes before SYNC are ignored; LEN=0 aborts.
        eq.push_back(3'd0);
        send(8'h33); send(8'hA5); send(8'h10); send(8'h00);
        wait_done("len_zero", 50);
        check("len_zero_busy", {31'd0, busy}, 32'd0);

        // LEN=17 > MAX_LEN aborts.
        eq.push_back(3'd0);
        send(8'hA5); send(8'h10); send(8'h11);
        wait_done("len_big", 50);

        // LEN=MAX_LEN at F8, wraps through 00..07.
        sum = 8'hF8 + 8'h10;
        for (int i = 0; i < 16; i++) push_wr(8'hF8 + 8'(i), 8'h30 + 8'(i));
        eq.push_back(3'd4);
        send(8'hA5); send(8'hF8); send(8'h10);
        for (int i = 0; i < 16; i++) begin
            send(8'h30 + 8'(i));
            sum = sum + 8'h30 + 8'(i);
        end
        send_chk(sum);
        wait_done("len_max", 80);

        // SYNC value inside a packet is plain data (sum 0x7C).
        push_wr(8'h30, 8'hA5); push_wr(8'h31, 8'hA5); eq.push_back(3'd4);
        send(8'hA5); send(8'h30); send(8'h02); send(8'hA5); send(8'hA5); send_chk(8'h7C);
        wait_done("sync_as_data", 50);

        // Overrun: byte during COMMIT is dropped, writes and pkt_ok still happen.
        push_wr(8'h20, 8'h01); push_wr(8'h21, 8'h02); push_wr(8'h22, 8'h03);
        eq.push_back(3'd3); eq.push_back(3'd4);
        send(8'hA5); send(8'h20); send(8'h03); send(8'h01); send(8'h02); send(8'h03); send_chk(8'h29);
        send(8'hEE);
        wait_done("overrun", 50);

        // Timeout: nothing may happen before ~50000 idle cycles.
        send(8'hA5); send(8'h10);
        repeat (49990) @(negedge clk);
        check("pre_timeout_busy", {31'd0, busy}, 32'd1);
        eq.push_back(3'd2);
        wait_done("timeout", 100);
        check("timeout_busy", {31'd0, busy}, 32'd0);
        check("timeout_code_held", {30'd0, err_code}, 32'd2);
        push_wr(8'h50, 8'h77); eq.push_back(3'd4);
        send(8'hA5); send(8'h50); send(8'h01); send(8'h77); send_chk(8'hC8);
        wait_done("after_timeout", 50);

        // Reset during COMMIT: the write in flight is cut and no more follow.
        send(8'hA5); send(8'h40); send(8'h03); send(8'h01); send(8'h02); send(8'h03); send_chk(8'h49);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rst_commit_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_commit_busy",  {31'd0, busy},  32'd0);
        check("rst_commit_addr",  {24'd0, wr_addr}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("final_wq_empty", wq.size(), 32'd0);
        check("final_eq_empty", eq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
